// File: rtl/pdm_pkg.sv
// Shared constants and width helpers for the PDM-to-PCM CIC decimator.
package pdm_pkg;

  localparam int CIC_ORDER      = 3;
  localparam int DEF_DECIM_LOG2 = 9;
  localparam int DEF_OUT_W      = 16;

  // Warm-up tracker: the first three decimated results carry the CIC transient.
  typedef enum logic [1:0] {
    WARM_0    = 2'd0,
    WARM_1    = 2'd1,
    WARM_2    = 2'd2,
    WARM_DONE = 2'd3
  } warm_state_e;

  function automatic int acc_width(input int decim_log2);
    return CIC_ORDER * decim_log2 + 1;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator: on enable, y = x - x_prev and the delay takes x.
module cic_comb_stage #(
  parameter int ACC_W = 28
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [ACC_W-1:0] x_i,
  output logic [ACC_W-1:0] y_o
);

  logic [ACC_W-1:0] dly_q;
  logic [ACC_W-1:0] dly_d;
  logic [ACC_W-1:0] y_q;
  logic [ACC_W-1:0] y_d;

  always_comb begin
    y_d   = y_q;
    dly_d = dly_q;
    if (en_i) begin
      y_d   = x_i - dly_q;
      dly_d = x_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dly_q <= '0;
      y_q   <= '0;
    end else begin
      dly_q <= dly_d;
      y_q   <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/pdm_decoder.sv
// 3rd-order CIC decimator turning a 1-bit PDM stream into unsigned PCM samples.
// Optional output clamp on full-scale input is enabled by defining PDM_DECODER_SAT_EN.
module pdm_decoder
  import pdm_pkg::*;
#(
  parameter int DECIM_LOG2 = DEF_DECIM_LOG2,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid
);

  localparam int ACC_W = acc_width(DECIM_LOG2);
  localparam logic [DECIM_LOG2-1:0] CNT_ONE = DECIM_LOG2'(1);

  logic [ACC_W-1:0]      i1_q, i2_q, i3_q;
  logic [ACC_W-1:0]      i1_d, i2_d, i3_d;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [2:0]            en_q, en_d;
  logic                  strobe;
  logic [ACC_W-1:0]      c1, c2, c3;
  warm_state_e           warm_q;
  logic [OUT_W-1:0]      sample_q;
  logic                  sample_valid_q;
  logic                  unused_c3;

  // Full scale R^3 sits at bit ACC_W-1; the sample is the OUT_W bits just below it.
  function automatic logic [OUT_W-1:0] map_sample(input logic [ACC_W-1:0] c);
`ifdef PDM_DECODER_SAT_EN
    return c[ACC_W-1] ? {OUT_W{1'b1}} : c[ACC_W-2 -: OUT_W];
`else
    return c[ACC_W-2 -: OUT_W];
`endif
  endfunction

  // Integrators run modulo 2^ACC_W; wrap-around cancels in the comb section.
  assign i1_d   = i1_q + {{(ACC_W-1){1'b0}}, din};
  assign i2_d   = i2_q + i1_q;
  assign i3_d   = i3_q + i2_q;
  assign strobe = &cnt_q;
  assign cnt_d  = cnt_q + CNT_ONE;
  assign en_d   = {en_q[1:0], strobe};

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q  <= '0;
      i2_q  <= '0;
      i3_q  <= '0;
      cnt_q <= '0;
      en_q  <= '0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      i3_q  <= i3_d;
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  cic_comb_stage #(.ACC_W(ACC_W)) u_comb1 (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (strobe),
    .x_i   (i3_q),
    .y_o   (c1)
  );

  cic_comb_stage #(.ACC_W(ACC_W)) u_comb2 (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en_q[0]),
    .x_i   (c1),
    .y_o   (c2)
  );

  cic_comb_stage #(.ACC_W(ACC_W)) u_comb3 (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (en_q[1]),
    .x_i   (c2),
    .y_o   (c3)
  );

  // Output stage: results are swallowed until the warm-up tracker reaches WARM_DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q         <= WARM_0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (en_q[2]) begin
        case (warm_q)
          WARM_0:  warm_q <= WARM_1;
          WARM_1:  warm_q <= WARM_2;
          WARM_2:  warm_q <= WARM_DONE;
          default: begin
            sample_q       <= map_sample(c3);
            sample_valid_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign unused_c3    = ^c3;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_pdm_decoder.sv
// Bench for pdm_decoder: CIC output predicted by convolving the input history with
// the triple-boxcar kernel, plus fixed expectations for the canonical densities.
module tb_pdm_decoder;

  localparam int DL    = 9;
  localparam int R     = 1 << DL;
  localparam int OUT_W = 16;
  localparam int ACC_W = 3 * DL + 1;
  localparam int HLEN  = 3 * R - 2;
  localparam int MAXC  = 12000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic [OUT_W-1:0] sample;
  logic             sample_valid;

  int               tests = 0;
  int               fails = 0;
  int               h[HLEN];
  bit               xs[MAXC+1];
  int               pe[$];
  logic [OUT_W-1:0] ps[$];
  int               chg;

  pdm_decoder #(.DECIM_LOG2(DL), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // Kernel of three cascaded length-R moving sums (sums to R^3).
  task automatic build_kernel();
    for (int n = 0; n < HLEN; n++) begin
      int s = 0;
      for (int k = 0; k < R; k++) begin
        int t = n - k;
        if (t >= 0 && t <= 2 * R - 2) s += (t < R) ? t + 1 : 2 * R - 1 - t;
      end
      h[n] = s;
    end
  endtask

  // Decimated result m is taken from inputs up to 3 edges before edge m*R.
  function automatic logic [OUT_W-1:0] model_sample(input int m);
    int top = m * R - 3;
    int lo  = (top - HLEN + 1 > 1) ? top - HLEN + 1 : 1;
    int c   = 0;
    for (int j = lo; j <= top; j++) if (xs[j]) c += h[top - j];
    c = c % (1 << ACC_W);
`ifdef PDM_DECODER_SAT_EN
    if (c >= (1 << (ACC_W - 1))) return {OUT_W{1'b1}};
`endif
    return OUT_W'(c >> (ACC_W - 1 - OUT_W));
  endfunction

  function automatic int n_pulses(input int ncyc);
    return (ncyc - 3) / R - 3;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    din = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives xs[1..n], one bit per edge starting at the current negedge; logs pulses.
  task automatic run(input int n);
    logic [OUT_W-1:0] prev;
    pe.delete();
    ps.delete();
    chg  = 0;
    prev = sample;
    for (int k = 1; k <= n; k++) begin
      din = xs[k];
      @(posedge clk);
      #1;
      if (sample_valid) begin
        pe.push_back(k);
        ps.push_back(sample);
      end else if (sample !== prev) begin
        chg++;
      end
      prev = sample;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset(4);
    tests++;
    if (sample !== '0) begin
      fails++;
      $display("FAIL reset_sample: got %h, expected 0000", sample);
    end
    tests++;
    if (sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b, expected 0", sample_valid);
    end
  endtask

  task automatic test_zero();
    do_reset(4);
    for (int k = 1; k <= 8 * R; k++) xs[k] = 1'b0;
    run(8 * R);
    tests++;
    if (pe.size() != n_pulses(8 * R)) begin
      fails++;
      $display("FAIL zero_count: got %0d pulses, expected %0d", pe.size(), n_pulses(8 * R));
    end
    for (int q = 0; q < pe.size(); q++) begin
      tests++;
      if (pe[q] != (q + 4) * R + 3) begin
        fails++;
        $display("FAIL zero_edge[%0d]: got edge %0d, expected %0d", q, pe[q], (q + 4) * R + 3);
      end
      tests++;
      if (ps[q] !== 16'h0000) begin
        fails++;
        $display("FAIL zero_sample[%0d]: got %h, expected 0000", q, ps[q]);
      end
    end
    tests++;
    if (chg != 0) begin
      fails++;
      $display("FAIL zero_stable: %0d changes between pulses, expected 0", chg);
    end
  endtask

  task automatic test_half();
    do_reset(2);
    for (int k = 1; k <= 10 * R; k++) xs[k] = k[0];
    run(10 * R);
    tests++;
    if (pe.size() != n_pulses(10 * R)) begin
      fails++;
      $display("FAIL half_count: got %0d pulses, expected %0d", pe.size(), n_pulses(10 * R));
    end
    for (int q = 0; q < pe.size(); q++) begin
      tests++;
      if (pe[q] != (q + 4) * R + 3) begin
        fails++;
        $display("FAIL half_edge[%0d]: got edge %0d, expected %0d", q, pe[q], (q + 4) * R + 3);
      end
      tests++;
      if (ps[q] !== 16'h8000 || ps[q] !== model_sample(q + 4)) begin
        fails++;
        $display("FAIL half_sample[%0d]: got %h, expected 8000 (model %h)", q, ps[q], model_sample(q + 4));
      end
    end
    tests++;
    if (chg != 0) begin
      fails++;
      $display("FAIL half_stable: %0d changes between pulses, expected 0", chg);
    end
  endtask

  task automatic test_full_scale();
    logic [OUT_W-1:0] exp_fs;
`ifdef PDM_DECODER_SAT_EN
    exp_fs = 16'hFFFF;
`else
    exp_fs = 16'h0000;
`endif
    do_reset(2);
    for (int k = 1; k <= 7 * R + 10; k++) xs[k] = 1'b1;
    run(7 * R + 10);
    tests++;
    if (pe.size() != n_pulses(7 * R + 10)) begin
      fails++;
      $display("FAIL full_count: got %0d pulses, expected %0d", pe.size(), n_pulses(7 * R + 10));
    end
    for (int q = 0; q < pe.size(); q++) begin
      tests++;
      if (ps[q] !== exp_fs || ps[q] !== model_sample(q + 4)) begin
        fails++;
        $display("FAIL full_sample[%0d]: got %h, expected %h", q, ps[q], exp_fs);
      end
    end
  endtask

  task automatic test_quarter();
    do_reset(2);
    for (int k = 1; k <= 20 * R; k++) xs[k] = (k % 4 == 1);
    run(20 * R);
    tests++;
    if (pe.size() != n_pulses(20 * R)) begin
      fails++;
      $display("FAIL quarter_count: got %0d pulses, expected %0d", pe.size(), n_pulses(20 * R));
    end
    for (int q = 0; q < pe.size(); q++) begin
      tests++;
      if (ps[q] !== 16'h4000 || ps[q] !== model_sample(q + 4)) begin
        fails++;
        $display("FAIL quarter_sample[%0d]: got %h, expected 4000 (model %h)", q, ps[q], model_sample(q + 4));
      end
    end
    tests++;
    if (pe.size() > 0 && pe[pe.size() - 1] != (pe.size() + 3) * R + 3) begin
      fails++;
      $display("FAIL quarter_last_edge: got %0d, expected %0d", pe[pe.size() - 1], (pe.size() + 3) * R + 3);
    end
  endtask

  task automatic test_random_density();
    for (int it = 0; it < 2; it++) begin
      int p = $urandom_range(100, 900);
      do_reset(3);
      for (int k = 1; k <= 9 * R; k++) xs[k] = ($urandom_range(0, 1023) < p);
      run(9 * R);
      tests++;
      if (pe.size() != n_pulses(9 * R)) begin
        fails++;
        $display("FAIL rand_count[%0d]: got %0d pulses, expected %0d", it, pe.size(), n_pulses(9 * R));
      end
      for (int q = 0; q < pe.size(); q++) begin
        tests++;
        if (ps[q] !== model_sample(q + 4)) begin
          fails++;
          $display("FAIL rand_sample[%0d][%0d]: got %h, expected %h (p=%0d)", it, q, ps[q], model_sample(q + 4), p);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(2);
    for (int k = 1; k <= 6 * R + 200; k++) xs[k] = k[0];
    run(6 * R + 200);
    rst = 1'b1;
    din = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (sample !== '0 || sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_clear: got sample %h valid %b, expected 0000 0", sample, sample_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4 * R + 10; k++) xs[k] = k[0];
    run(4 * R + 10);
    tests++;
    if (pe.size() != 1) begin
      fails++;
      $display("FAIL midrst_count: got %0d pulses, expected 1", pe.size());
    end else begin
      tests++;
      if (pe[0] != 4 * R + 3) begin
        fails++;
        $display("FAIL midrst_edge: got edge %0d, expected %0d", pe[0], 4 * R + 3);
      end
      tests++;
      if (ps[0] !== 16'h8000) begin
        fails++;
        $display("FAIL midrst_sample: got %h, expected 8000", ps[0]);
      end
    end
  endtask

  // First-order sigma-delta DAC stand-in with a constant 16-bit input.
  task automatic test_loopback();
    int acc = 0;
    do_reset(2);
    for (int k = 1; k <= 8 * R; k++) begin
      acc += 16'h3000;
      if (acc >= 65536) begin
        xs[k] = 1'b1;
        acc  -= 65536;
      end else begin
        xs[k] = 1'b0;
      end
    end
    run(8 * R);
    tests++;
    if (pe.size() != n_pulses(8 * R)) begin
      fails++;
      $display("FAIL loop_count: got %0d pulses, expected %0d", pe.size(), n_pulses(8 * R));
    end
    for (int q = 0; q < pe.size(); q++) begin
      int diff = int'(ps[q]) - 'h3000;
      tests++;
      if (diff < -2 || diff > 2 || ps[q] !== model_sample(q + 4)) begin
        fails++;
        $display("FAIL loop_sample[%0d]: got %h, expected 3000+-2 (model %h)", q, ps[q], model_sample(q + 4));
      end
    end
  endtask

  initial begin
    build_kernel();
    test_reset();
    test_zero();
    test_half();
    test_full_scale();
    test_quarter();
    test_random_density();
    test_mid_reset();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
